packet_receiver_np: RTL and testbench
=====================================

# packet_receiver_np

Parametrised, store-and-forward successor to the router input-port receiver. It accepts byte-serial packets (SRC, DST, SIZE, payload, CRC) on `pdata`, screens each one, and stages it in an internal buffer. Good packets are drained into one of NUM_PORTS output-FIFO write ports. Bad packets are dropped and counted; a good packet never reaches a FIFO before its CRC has been verified.

## Interface
Parameters:
- NUM_PORTS, 4: output FIFO write ports (2..8); port select width PSEL_W = clog2(NUM_PORTS).
- DATA_W, 8: byte width of `pdata` and the FIFO data.
- ADDR_W, 4: FIFO write-address width; pointers wrap modulo 2^ADDR_W.
- MAX_PAYLOAD, 8: staging buffer depth in payload bytes.
- TRUST_MAX, 15: a source is trusted iff SRC <= TRUST_MAX.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk1  in  1  clock; one clock, all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- packet_valid_i  in  1  sender has a byte on `pdata`.
- pdata  in  DATA_W  packet byte.
- wfull  in  NUM_PORTS  per-port FIFO full flag.
- stop_packet_send  out  1  receiver cannot accept; sender holds the current byte.
- winc  out  NUM_PORTS  per-port write strobe.
- wdata  out  NUM_PORTS*DATA_W  per-port write data; port p uses bits [p*DATA_W +: DATA_W].
- waddr  out  NUM_PORTS*ADDR_W  per-port write pointer.
- pkt_ok  out  1  one-cycle pulse when the last byte of a good packet is written.
- pkt_err  out  1  one-cycle pulse when a packet is dropped.
- ok_cnt, drop_cnt  out  CNT_W each  saturating counts of good and dropped packets.

## Operation
- A byte is accepted on an edge where packet_valid_i=1 and stop_packet_send=0.
- States and transitions:
  - IDLE: accept SRC, go to DST.
  - DST: accept DST, go to SIZE.
  - SIZE: accept SIZE; go to PAY if SIZE>0, otherwise go to CRC.
  - PAY: accept SIZE payload bytes, then go to CRC.
  - CRC: accept the CRC byte.
  - DRAIN: write the packet into the selected FIFO, then return to IDLE.
- Running check value = XOR of SRC, DST, SIZE and every payload byte. A packet is good iff the received CRC byte equals this value.
- Port select p = DST[DATA_W-1 -: PSEL_W].
- Drop conditions, all evaluated when the CRC byte is accepted:
  - SRC > TRUST_MAX,
  - p >= NUM_PORTS,
  - SIZE > MAX_PAYLOAD,
  - CRC mismatch.
- Oversized payload bytes beyond MAX_PAYLOAD are consumed but not stored.
- A dropped packet goes CRC -> IDLE, pulses pkt_err and increments drop_cnt. stop_packet_send is never raised for it.
- packet_valid_i=0 while in DST, SIZE, PAY or CRC aborts the packet: go to IDLE, pulse pkt_err, increment drop_cnt. In IDLE, packet_valid_i=0 is simply idle.
- A good packet goes CRC -> DRAIN. DRAIN writes SIZE+1 bytes to port p: first the SIZE byte, then the payload in arrival order.
- Write rules in DRAIN:
  - winc[p] = !wfull[p] (combinational).
  - wdata[p] = current byte; waddr[p] = wptr[p].
  - wptr[p] and the drain index advance on each write.
  - wfull[p] high stalls the drain with no write and no loss.
- After the final write: pkt_ok pulses, ok_cnt increments, next state is IDLE.
- Other ports' winc stay 0 throughout. waddr[q] always shows wptr[q].
- Counters saturate at 2^CNT_W-1.

## Timing
- Reset values: state IDLE, stop_packet_send 0, winc 0, wdata 0, wptr/waddr 0, pkt_ok 0, pkt_err 0, ok_cnt 0, drop_cnt 0, buffer contents don't-care.
- Reset asserted mid-packet or mid-drain: immediate abort; the partial packet is neither written further nor counted.
- stop_packet_send is registered. It is 1 exactly while in DRAIN: it rises the cycle after the CRC byte is accepted and falls the cycle after the final write.
- First winc occurs in the cycle right after the CRC edge. With no wfull stalls, a drain takes SIZE+1 cycles.
- Back-to-back packets:
  - After a drop, the next SRC can be accepted on the very next edge.
  - After a good packet, the next SRC can be accepted on the first edge after DRAIN ends.
- waddr wraps from 2^ADDR_W-1 to 0. Full/empty policing is the FIFO's responsibility via wfull.
- Simultaneous events:
  - wfull[p] rising in the same cycle as the last drain byte: that write does not occur; retry the next cycle.
  - Reset takes priority over everything.

## Test plan
- Good packet SRC=1, DST=6, SIZE=2, data 171,172, CRC=2 -> port 0 gets three writes with wdata 2,171,172 at waddr 0,1,2; stop_packet_send high for 3 cycles; pkt_ok pulses once; ok_cnt=1.
- SRC=1, DST=150 (port 2), SIZE=1, data 7, CRC=145, with wfull[2]=1 for 2 cycles after the first write -> writes 1 then 7, with a 2-cycle stall between them; stop_packet_send high for 4 cycles; winc[0,1,3] stay 0.
- Untrusted SRC=123, and separately CRC=222 sent instead of the correct value -> no winc on any port; stop_packet_send stays 0; pkt_err pulses; drop_cnt=2; next packet accepted on the following edge.
- SIZE=9 (> MAX_PAYLOAD) with valid CRC -> all bytes consumed, packet dropped. packet_valid_i=0 after SIZE -> abort to IDLE, drop_cnt increments.
- 17 one-byte packets to port 1 -> waddr[1] wraps 15 -> 0; ok_cnt=17; with CNT_W=4, ok_cnt saturates at 15.
- rst=0 during DRAIN -> all outputs return to reset values asynchronously; after release, a new good packet drains from waddr 0.

Source files
------------

// File: rtl/packet_receiver_np.sv
// Store-and-forward router input receiver: screens SRC/DST/SIZE/payload/CRC packets,
// stages good ones in a local buffer and drains them into one of NUM_PORTS FIFO write ports.
module packet_receiver_np #(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int MAX_PAYLOAD = 8,
    parameter int TRUST_MAX   = 15,
    parameter int CNT_W       = 8
) (
    input  logic                        clk1,
    input  logic                        rst,
    input  logic                        packet_valid_i,
    input  logic [DATA_W-1:0]           pdata,
    input  logic [NUM_PORTS-1:0]        wfull,
    output logic                        stop_packet_send,
    output logic [NUM_PORTS-1:0]        winc,
    output logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS*ADDR_W-1:0] waddr,
    output logic                        pkt_ok,
    output logic                        pkt_err,
    output logic [CNT_W-1:0]            ok_cnt,
    output logic [CNT_W-1:0]            drop_cnt
);
    localparam int PSEL_W = $clog2(NUM_PORTS);
    localparam int BUF_AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [31:0] TRUST_U = TRUST_MAX;
    localparam logic [31:0] MAXP_U  = MAX_PAYLOAD;
    localparam logic [31:0] NP_U    = NUM_PORTS;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_DST, S_SIZE, S_PAY, S_CRC, S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   src_q, src_d;
    logic [DATA_W-1:0]   size_q, size_d;
    logic [DATA_W-1:0]   chk_q, chk_d;
    logic [DATA_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   idx_q, idx_d;
    logic [PSEL_W-1:0]   port_q, port_d;
    logic                stop_q;
    logic                pkt_ok_q, pkt_ok_d;
    logic                pkt_err_q, pkt_err_d;
    logic [CNT_W-1:0]    ok_cnt_q, drop_cnt_q;
    logic [DATA_W-1:0]   buf_q [MAX_PAYLOAD];
    logic                accept;
    logic                buf_we;
    logic                pkt_good;
    logic [BUF_AW-1:0]   rd_addr;
    logic [DATA_W-1:0]   drain_byte;

    assign accept = packet_valid_i && !stop_q;

    // Every screening rule is applied together at the CRC byte, so oversized
    // payloads are still fully consumed before the drop is signalled.
    assign pkt_good = (pdata == chk_q)
                   && (32'(src_q)  <= TRUST_U)
                   && (32'(port_q) <  NP_U)
                   && (32'(size_q) <= MAXP_U);

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        port_d    = port_q;
        size_d    = size_q;
        chk_d     = chk_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pkt_ok_d  = 1'b0;
        pkt_err_d = 1'b0;
        buf_we    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    src_d   = pdata;
                    chk_d   = pdata;
                    state_d = S_DST;
                end
            end
            S_DST: begin
                if (!packet_valid_i) begin
                    pkt_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    port_d  = pdata[DATA_W-1 -: PSEL_W];
                    chk_d   = chk_q ^ pdata;
                    state_d = S_SIZE;
                end
            end
            S_SIZE: begin
                if (!packet_valid_i) begin
                    pkt_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    size_d  = pdata;
                    chk_d   = chk_q ^ pdata;
                    cnt_d   = '0;
                    state_d = (pdata != '0) ? S_PAY : S_CRC;
                end
            end
            S_PAY: begin
                if (!packet_valid_i) begin
                    pkt_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    buf_we = (32'(cnt_q) < MAXP_U);
                    chk_d  = chk_q ^ pdata;
                    cnt_d  = cnt_q + ONE;
                    if (cnt_q == size_q - ONE) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (!packet_valid_i) begin
                    pkt_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (pkt_good) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    pkt_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Index 0 is the SIZE byte; index k>0 is payload byte k-1.
                if (!wfull[port_q]) begin
                    idx_d = idx_q + ONE;
                    if (idx_q == size_q) begin
                        pkt_ok_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            port_q     <= '0;
            size_q     <= '0;
            chk_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            port_q    <= port_d;
            size_q    <= size_d;
            chk_q     <= chk_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stop_q    <= (state_d == S_DRAIN);
            pkt_ok_q  <= pkt_ok_d;
            pkt_err_q <= pkt_err_d;
            if (pkt_ok_d && (ok_cnt_q != '1)) begin
                ok_cnt_q <= ok_cnt_q + 1'b1;
            end
            if (pkt_err_d && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    // Staging buffer carries no reset; its contents are only read after being written.
    always_ff @(posedge clk1) begin
        if (buf_we) begin
            buf_q[BUF_AW'(cnt_q)] <= pdata;
        end
    end

    assign rd_addr    = BUF_AW'(idx_q - ONE);
    assign drain_byte = (idx_q == '0) ? size_q : buf_q[rd_addr];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic              sel;
            logic [ADDR_W-1:0] wptr_q;

            assign sel                        = (state_q == S_DRAIN) && (port_q == PSEL_W'(gi));
            assign winc[gi]                   = sel && !wfull[gi];
            assign wdata[gi*DATA_W +: DATA_W] = sel ? drain_byte : '0;
            assign waddr[gi*ADDR_W +: ADDR_W] = wptr_q;

            always_ff @(posedge clk1 or negedge rst) begin
                if (!rst) begin
                    wptr_q <= '0;
                end else if (winc[gi]) begin
                    wptr_q <= wptr_q + 1'b1;
                end
            end
        end
    endgenerate

    assign stop_packet_send = stop_q;
    assign pkt_ok           = pkt_ok_q;
    assign pkt_err          = pkt_err_q;
    assign ok_cnt           = ok_cnt_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_packet_receiver_np.sv
// Directed bench for packet_receiver_np: a default instance plus a CNT_W=4 instance
// sharing the same stimulus, so counter saturation is observable alongside normal counts.
module tb_packet_receiver_np;
    logic        clk1 = 1'b0;
    logic        rst = 1'b0;
    logic        packet_valid_i = 1'b0;
    logic [7:0]  pdata = 8'd0;
    logic [3:0]  wfull = 4'd0;
    logic        stop_packet_send, pkt_ok, pkt_err;
    logic [3:0]  winc;
    logic [31:0] wdata;
    logic [15:0] waddr;
    logic [7:0]  ok_cnt, drop_cnt;
    logic        stop4, pkt_ok4, pkt_err4;
    logic [3:0]  winc4;
    logic [31:0] wdata4;
    logic [15:0] waddr4;
    logic [3:0]  ok_cnt4, drop_cnt4;

    int n_assert = 0;
    int n_fail   = 0;

    packet_receiver_np dut (
        .clk1(clk1), .rst(rst), .packet_valid_i(packet_valid_i), .pdata(pdata),
        .wfull(wfull), .stop_packet_send(stop_packet_send), .winc(winc),
        .wdata(wdata), .waddr(waddr), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
        .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
    );

    packet_receiver_np #(.CNT_W(4)) dut4 (
        .clk1(clk1), .rst(rst), .packet_valid_i(packet_valid_i), .pdata(pdata),
        .wfull(wfull), .stop_packet_send(stop4), .winc(winc4),
        .wdata(wdata4), .waddr(waddr4), .pkt_ok(pkt_ok4), .pkt_err(pkt_err4),
        .ok_cnt(ok_cnt4), .drop_cnt(drop_cnt4)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        packet_valid_i = 1'b1;
        pdata = b;
        cyc();
    endtask

    task automatic send_last(input logic [7:0] b);
        send(b);
        packet_valid_i = 1'b0;
        pdata = 8'd0;
    endtask

    task automatic exp_write(input string tag, input int p, input logic [7:0] d, input logic [3:0] a);
        chk({tag, ".stop"},   32'(stop_packet_send), 32'd1);
        chk({tag, ".winc"},   32'(winc), 32'(1) << p);
        chk({tag, ".wdata"},  wdata, 32'(d) << (8 * p));
        chk({tag, ".waddr"},  32'(waddr[4*p +: 4]), 32'(a));
        chk({tag, ".winc4"},  32'(winc4), 32'(1) << p);
        chk({tag, ".wdata4"}, wdata4, 32'(d) << (8 * p));
        chk({tag, ".waddr4"}, 32'(waddr4[4*p +: 4]), 32'(a));
        chk({tag, ".stop4"},  32'(stop4), 32'd1);
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, ".stop"}, 32'(stop_packet_send), 32'd0);
        chk({tag, ".winc"}, 32'(winc), 32'd0);
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        exp_idle("rst");
        chk("rst.wdata", wdata, 32'd0);
        chk("rst.waddr", 32'(waddr), 32'd0);
        chk("rst.pkt_ok", 32'(pkt_ok), 32'd0);
        chk("rst.pkt_err", 32'(pkt_err), 32'd0);
        chk("rst.ok_cnt", 32'(ok_cnt), 32'd0);
        chk("rst.drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b1;
        cyc();

        // Good packet to port 0: 1,6,2,171,172, CRC 2
        send(8'd1); send(8'd6); send(8'd2); send(8'd171); send(8'd172);
        exp_idle("t1.pre");
        send_last(8'd2);
        exp_write("t1.w0", 0, 8'd2, 4'd0);
        cyc();
        exp_write("t1.w1", 0, 8'd171, 4'd1);
        cyc();
        exp_write("t1.w2", 0, 8'd172, 4'd2);
        cyc();
        exp_idle("t1.end");
        chk("t1.pkt_ok", 32'(pkt_ok), 32'd1);
        chk("t1.ok_cnt", 32'(ok_cnt), 32'd1);
        cyc();
        chk("t1.pkt_ok_pulse", 32'(pkt_ok), 32'd0);

        // Port 2 with a two-cycle wfull stall after the first write
        send(8'd1); send(8'd150); send(8'd1); send(8'd7);
        send_last(8'd145);
        exp_write("t2.w0", 2, 8'd1, 4'd0);
        cyc();
        wfull = 4'b0100;
        #1;
        chk("t2.stall1.winc", 32'(winc), 32'd0);
        chk("t2.stall1.stop", 32'(stop_packet_send), 32'd1);
        cyc();
        chk("t2.stall2.winc", 32'(winc), 32'd0);
        chk("t2.stall2.waddr", 32'(waddr[11:8]), 32'd1);
        cyc();
        wfull = 4'b0000;
        #1;
        exp_write("t2.w1", 2, 8'd7, 4'd1);
        cyc();
        exp_idle("t2.end");
        chk("t2.pkt_ok", 32'(pkt_ok), 32'd1);
        chk("t2.ok_cnt", 32'(ok_cnt), 32'd2);

        // Untrusted SRC, then bad CRC, then a good packet, all back to back
        send(8'd123); send(8'd6); send(8'd0); send(8'd125);
        exp_idle("t3.untrusted");
        chk("t3.untrusted.pkt_err", 32'(pkt_err), 32'd1);
        chk("t3.untrusted.drop_cnt", 32'(drop_cnt), 32'd1);
        send(8'd1);
        chk("t3.pkt_err_pulse", 32'(pkt_err), 32'd0);
        send(8'd6); send(8'd0); send(8'd222);
        exp_idle("t3.badcrc");
        chk("t3.badcrc.pkt_err", 32'(pkt_err), 32'd1);
        chk("t3.badcrc.pkt_err4", 32'(pkt_err4), 32'd1);
        chk("t3.badcrc.drop_cnt", 32'(drop_cnt), 32'd2);
        send(8'd2); send(8'd64); send(8'd0);
        send_last(8'd66);
        exp_write("t3.good", 1, 8'd0, 4'd0);
        cyc();
        chk("t3.good.pkt_ok", 32'(pkt_ok), 32'd1);
        chk("t3.good.ok_cnt", 32'(ok_cnt), 32'd3);

        // Oversized payload with a valid CRC is consumed and dropped
        send(8'd1); send(8'd6); send(8'd9);
        for (int i = 1; i <= 9; i++) begin
            send(8'(i));
        end
        chk("t4.big.stop", 32'(stop_packet_send), 32'd0);
        send_last(8'd15);
        exp_idle("t4.big");
        chk("t4.big.pkt_err", 32'(pkt_err), 32'd1);
        chk("t4.big.drop_cnt", 32'(drop_cnt), 32'd3);
        cyc();
        exp_idle("t4.big.after");

        // Abort by dropping packet_valid_i after SIZE
        send(8'd1); send(8'd6); send(8'd2);
        packet_valid_i = 1'b0;
        cyc();
        chk("t4.abort.pkt_err", 32'(pkt_err), 32'd1);
        chk("t4.abort.drop_cnt", 32'(drop_cnt), 32'd4);
        chk("t4.abort.drop_cnt4", 32'(drop_cnt4), 32'd4);
        cyc();
        chk("t4.abort.pulse", 32'(pkt_err), 32'd0);

        // 17 one-byte packets to port 1; next SRC is held on pdata during each drain
        for (int i = 0; i < 17; i++) begin
            send(8'd3); send(8'd64); send(8'd0); send(8'd67);
            packet_valid_i = (i < 16);
            pdata = (i < 16) ? 8'd3 : 8'd0;
            exp_write($sformatf("t5.wrap%0d", i), 1, 8'd0, 4'((1 + i) % 16));
            cyc();
            chk($sformatf("t5.pkt_ok%0d", i), 32'(pkt_ok), 32'd1);
            chk($sformatf("t5.pkt_ok4_%0d", i), 32'(pkt_ok4), 32'd1);
            chk($sformatf("t5.ok_cnt%0d", i), 32'(ok_cnt), 32'(4 + i));
            chk($sformatf("t5.ok_cnt4_%0d", i), 32'(ok_cnt4), (4 + i > 15) ? 32'd15 : 32'(4 + i));
        end

        // Reset asserted mid-drain, then a fresh packet drains from waddr 0
        send(8'd1); send(8'd6); send(8'd2); send(8'd171); send(8'd172);
        send_last(8'd2);
        exp_write("t6.w0", 0, 8'd2, 4'd3);
        cyc();
        exp_write("t6.w1", 0, 8'd171, 4'd4);
        rst = 1'b0;
        #1;
        exp_idle("t6.rst");
        chk("t6.rst.wdata", wdata, 32'd0);
        chk("t6.rst.waddr", 32'(waddr), 32'd0);
        chk("t6.rst.ok_cnt", 32'(ok_cnt), 32'd0);
        chk("t6.rst.drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t6.rst.pkt_ok", 32'(pkt_ok), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        send(8'd1); send(8'd150); send(8'd1); send(8'd7);
        send_last(8'd145);
        exp_write("t6.n0", 2, 8'd1, 4'd0);
        cyc();
        exp_write("t6.n1", 2, 8'd7, 4'd1);
        cyc();
        exp_idle("t6.end");
        chk("t6.pkt_ok", 32'(pkt_ok), 32'd1);
        chk("t6.ok_cnt", 32'(ok_cnt), 32'd1);
        chk("t6.ok_cnt4", 32'(ok_cnt4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
